// File: rtl/prog_ctr_stack.sv
// Fetch-stage program counter with relative branches, absolute jumps, a LIFO
// call/return stack, a halt state and sticky stack overflow/underflow faults.
module prog_ctr_stack #(
    parameter int             W        = 8,
    parameter int             DEPTH    = 4,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic [2:0]                   Op,
    input  logic                         Zero,
    input  logic                         BrPol,
    input  logic [W-1:0]                 Target,
    output logic [W-1:0]                 PC,
    output logic                         Taken,
    output logic                         Halted,
    output logic [1:0]                   Fault,
    output logic [$clog2(DEPTH+1)-1:0]   Depth
);

    localparam int DW  = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STK = 1 << AW;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_BRB  = 3'b001;
    localparam logic [2:0] OP_BRF  = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    logic [0:0]    r_state;
    logic [W-1:0]  r_pc;
    logic          r_taken;
    logic [1:0]    r_fault;
    logic [DW-1:0] r_depth;
    logic [W-1:0]  r_stack [0:STK-1];

    logic [0:0]    w_state_next;
    logic [W-1:0]  w_pc_next;
    logic          w_taken_next;
    logic [1:0]    w_fault_next;
    logic [DW-1:0] w_depth_next;
    logic          w_push;

    logic [W-1:0]  w_pc_inc;
    logic          w_br_taken;
    logic          w_stack_full;
    logic          w_stack_empty;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;
    logic [W-1:0]  w_top;

    assign w_pc_inc      = r_pc + 1'b1;
    assign w_br_taken    = (Zero == BrPol);
    assign w_stack_full  = (r_depth == DW'(DEPTH));
    assign w_stack_empty = (r_depth == '0);
    // Modulo-2^AW indexing also yields the right top slot when a power-of-two stack is full.
    assign w_wr_idx      = r_depth[AW-1:0];
    assign w_top_idx     = w_wr_idx - 1'b1;
    assign w_top         = r_stack[w_top_idx];

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_taken_next = 1'b0;
        w_fault_next = r_fault;
        w_depth_next = r_depth;
        w_push       = 1'b0;
        if (!Stall && (r_state == ST_RUN)) begin
            case (Op)
                OP_INC: w_pc_next = w_pc_inc;
                OP_BRB: begin
                    if (w_br_taken) begin
                        w_pc_next    = r_pc - Target;
                        w_taken_next = 1'b1;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
                OP_BRF: begin
                    if (w_br_taken) begin
                        w_pc_next    = r_pc + Target;
                        w_taken_next = 1'b1;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
                OP_JMP: begin
                    w_pc_next    = Target;
                    w_taken_next = 1'b1;
                end
                OP_CALL: begin
                    if (w_stack_full) begin
                        w_fault_next[1] = 1'b1;
                        w_state_next    = ST_HALT;
                    end else begin
                        w_push       = 1'b1;
                        w_pc_next    = Target;
                        w_depth_next = r_depth + 1'b1;
                        w_taken_next = 1'b1;
                    end
                end
                OP_RET: begin
                    if (w_stack_empty) begin
                        w_fault_next[0] = 1'b1;
                        w_state_next    = ST_HALT;
                    end else begin
                        w_pc_next    = w_top;
                        w_depth_next = r_depth - 1'b1;
                        w_taken_next = 1'b1;
                    end
                end
                OP_HALT: w_state_next = ST_HALT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
            r_fault <= 2'b00;
            r_depth <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_taken <= w_taken_next;
            r_fault <= w_fault_next;
            r_depth <= w_depth_next;
        end
    end

    // Stack storage is deliberately left uninitialised by reset.
    always_ff @(posedge Clk) begin
        if (Reset && w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign PC     = r_pc;
    assign Taken  = r_taken;
    assign Halted = (r_state == ST_HALT);
    assign Fault  = r_fault;
    assign Depth  = r_depth;

endmodule

// File: tb/tb_prog_ctr_stack.sv
// Randomised plus directed bench for prog_ctr_stack, checked by a queue-based
// scoreboard fed from an abstract model of the counter and its return stack.
module tb_prog_ctr_stack;

    localparam int W = 8;
    localparam int DEPTH = 4;
    localparam logic [W-1:0] RESET_PC = 8'h10;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic [2:0]    op;
    logic          zero;
    logic          brpol;
    logic [W-1:0]  target;
    logic [W-1:0]  pc;
    logic          taken;
    logic          halted;
    logic [1:0]    fault;
    logic [2:0]    depth;

    prog_ctr_stack #(.W(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk(clk), .Reset(rst_n), .Stall(stall), .Op(op), .Zero(zero),
        .BrPol(brpol), .Target(target), .PC(pc), .Taken(taken),
        .Halted(halted), .Fault(fault), .Depth(depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       pc;
        bit       taken;
        bit       halted;
        bit [1:0] fault;
        int       depth;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn = 0;

    // Reference model state.
    int       m_pc;
    int       m_stk[$];
    bit       m_halt;
    bit       m_taken;
    bit [1:0] m_fault;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", name, got, want, n_txn);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: pc=%02h taken=%0d halted=%0d fault=%b depth=%0d", n_txn, pc, taken, halted, fault, depth);
            chk("pc", int'(pc), e.pc);
            chk("taken", int'(taken), int'(e.taken));
            chk("halted", int'(halted), int'(e.halted));
            chk("fault", int'(fault), int'(e.fault));
            chk("depth", int'(depth), e.depth);
        end
    end

    task automatic model(input bit r, input bit s, input int o, input bit z, input bit p, input int t);
        m_taken = 1'b0;
        if (!r) begin
            m_pc = int'(RESET_PC);
            m_stk.delete();
            m_halt = 1'b0;
            m_fault = 2'b00;
        end else if (!s && !m_halt) begin
            case (o)
                0: m_pc = (m_pc + 1) % 256;
                1: if (z == p) begin m_pc = (m_pc - t + 256) % 256; m_taken = 1'b1; end
                   else m_pc = (m_pc + 1) % 256;
                2: if (z == p) begin m_pc = (m_pc + t) % 256; m_taken = 1'b1; end
                   else m_pc = (m_pc + 1) % 256;
                3: begin m_pc = t; m_taken = 1'b1; end
                4: if (m_stk.size() == DEPTH) begin m_fault[1] = 1'b1; m_halt = 1'b1; end
                   else begin m_stk.push_back((m_pc + 1) % 256); m_pc = t; m_taken = 1'b1; end
                5: if (m_stk.size() == 0) begin m_fault[0] = 1'b1; m_halt = 1'b1; end
                   else begin m_pc = m_stk.pop_back(); m_taken = 1'b1; end
                6: m_halt = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit s, input int o, input bit z, input bit p, input int t);
        exp_t e;
        rst_n = r; stall = s; op = 3'(o); zero = z; brpol = p; target = 8'(t);
        model(r, s, o, z, p, t);
        @(posedge clk);
        e.pc = m_pc; e.taken = m_taken; e.halted = m_halt; e.fault = m_fault; e.depth = m_stk.size();
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; stall = 1'b0; op = 3'd7; zero = 1'b0; brpol = 1'b0; target = '0;
        #2;
        // Reset and increment.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        // Branch polarity.
        step(1, 0, 3, 0, 0, 8'h20);
        step(1, 0, 1, 0, 0, 5);
        step(1, 0, 2, 1, 0, 5);
        step(1, 0, 2, 1, 1, 5);
        // Wrap-around.
        step(1, 0, 3, 0, 0, 8'hFE);
        step(1, 0, 2, 1, 1, 3);
        step(1, 0, 3, 0, 0, 8'h02);
        step(1, 0, 1, 0, 0, 4);
        // Nested call/return.
        step(1, 0, 3, 0, 0, 8'h05);
        step(1, 0, 4, 0, 0, 8'h40);
        step(1, 0, 4, 0, 0, 8'h80);
        step(1, 0, 5, 0, 0, 0);
        step(1, 0, 5, 0, 0, 0);
        // Overflow, then ops ignored while halted.
        for (int i = 0; i < 5; i++) step(1, 0, 4, 0, 0, 8'h60 + i);
        step(1, 0, 3, 0, 0, 8'h33);
        step(1, 0, 0, 0, 0, 0);
        // Underflow after reset.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Stall and reset priority.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 8'h55);
        step(0, 1, 3, 0, 0, 8'h55);
        // Randomised operation mix.
        for (int i = 0; i < 1500; i++) begin
            bit r;
            bit s;
            r = m_halt ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) != 0);
            s = ($urandom_range(0, 7) == 0);
            step(r, s, (($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_ctr_stack.md
# prog_ctr_stack

Parametrised program counter with conditional relative branches, absolute jumps, a hardware call/return stack and a halt state. Sits in the fetch stage, drives the instruction-memory address, and takes its control (`Op`, `Zero`, `Target`) from the decode/ALU stage. It generalises the plain PC-relative counter: configurable width, stack depth, branch polarity, stall, and fault detection.

## Interface
- `W`, 8: PC and Target width.
- `DEPTH`, 4: return-stack entries (>=1).
- `RESET_PC`, 0: PC value loaded on reset.
- `Clk`  in  1  clock, all state updates on rising edge.
- `Reset`  in  1  synchronous, active-low reset. Sampled on `Clk` rising edge; 0 = reset.
- `Stall`  in  1  1 = hold all state this cycle.
- `Op`  in  3  operation select (see Operation).
- `Zero`  in  1  ALU zero flag.
- `BrPol`  in  1  conditional branch taken when `Zero == BrPol`.
- `Target`  in  W  offset magnitude (relative ops) or absolute address (jump/call).
- `PC`  out  W  current program counter.
- `Taken`  out  1  1 for the cycle after a redirect (branch taken, jump, call, return).
- `Halted`  out  1  1 while in HALT state.
- `Fault`  out  2  sticky {Overflow, Underflow}.
- `Depth`  out  $clog2(DEPTH+1)  current stack occupancy.

## Operation
- States: RUN, HALT. Reset -> RUN. HALT exits only through reset.
- Op codes, evaluated in RUN with `Stall`=0:
  - 000 INC: PC <= PC+1.
  - 001 BRB: if taken, PC <= PC-Target; else PC+1.
  - 010 BRF: if taken, PC <= PC+Target; else PC+1.
  - 011 JMP: PC <= Target.
  - 100 CALL: push PC+1, PC <= Target, Depth+1.
  - 101 RET: PC <= top of stack, pop, Depth-1.
  - 110 HALT: PC holds, go to HALT.
  - 111 NOP: PC holds.
- Taken condition for BRB/BRF: `Zero == BrPol`. With BrPol=0 and Op=BRB, behaviour matches the previous counter.
- Arithmetic is unsigned modulo 2^W. Wrap-around is legal and not flagged.
- CALL when Depth==DEPTH:
  - no push, PC holds.
  - Fault[1] set, go to HALT.
- RET when Depth==0:
  - PC holds.
  - Fault[0] set, go to HALT.
- In HALT: PC, stack, Depth and Fault hold. Op is ignored and Taken=0.
- `Stall`=1 holds PC, stack, Depth, state and Fault, and drives Taken=0. Stall is ignored when a reset is active.
- Stack is LIFO. Entries above Depth are don't-care and are never read.

## Timing
- Reset (Reset=0 at an edge) has priority over everything. After that edge:
  - PC=RESET_PC, Depth=0, Fault=00, Halted=0, Taken=0.
  - Stack contents are not cleared.
- A reset mid-CALL or mid-RET discards that operation.
- Op, Zero, BrPol and Target are sampled at edge N. The new PC is visible after edge N (1-cycle latency, registered).
- Taken is registered and aligned with the redirected PC value.
- Halted rises in the cycle after the HALT op or fault edge. Fault bits are set at the same edge.
- RET immediately following a CALL returns that CALL's PC+1. No bypass bubble: the push and pop resolve at consecutive edges.
- No combinational path from inputs to any output.

## Test plan
- Reset/INC (W=8, RESET_PC=0x10): hold Reset=0 for 2 cycles, then 4× INC -> PC 0x10,0x11,0x12,0x13,0x14; Taken=0 throughout.
- Branch polarity: PC=0x20, Target=5.
  - BRB with Zero=0, BrPol=0 -> PC=0x1B, Taken=1.
  - BRF with Zero=1, BrPol=0 -> PC=0x1C (not taken).
  - BRF with Zero=1, BrPol=1 -> PC=0x21.
- Wrap: PC=0xFE, BRF taken with Target=3 -> PC=0x01, no fault. PC=0x02, BRB taken with Target=4 -> PC=0xFE.
- Nested call/return (DEPTH=4): CALL 0x40 at PC 0x05, CALL 0x80 at PC 0x40, RET, RET:
  - PC sequence 0x40, 0x80, 0x41, 0x06.
  - Depth 1,2,1,0.
- Overflow/underflow:
  - 4 CALLs, then a 5th CALL -> PC holds, Fault=10, Halted=1; later Ops ignored.
  - Reset, then RET at Depth 0 -> Fault=01, Halted=1, PC unchanged.
- Stall/reset priority:
  - Stall=1 with Op=JMP 0x55 -> PC unchanged, Taken=0.
  - Reset=0 together with Stall=1 -> PC=RESET_PC on the next edge.
